// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/response bundle between the fetch unit (master)
// and instruction memory (slave).
interface if_fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch producer: owns the fetch PC, issues in-order imem requests,
// buffers returned words with their PCs and presents the head entry to IF/ID.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic                   branch_taken,
  input  logic [31:0]            branch_target,
  if_fetch_unit_if.master        imem,
  output logic [31:0]            pc,
  output logic [31:0]            instr_out,
  output logic                   instr_valid
);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;

  logic [31:0] pc_mem_q   [FIFO_DEPTH];
  logic [31:0] data_mem_q [FIFO_DEPTH];
  logic [31:0] tag_mem_q  [FIFO_DEPTH];

  logic        req_fire, push, pop, room;
  logic [CW:0] occupancy;

  always_comb begin
    occupancy           = {1'b0, count_q} + {1'b0, inflight_q};
    room                = occupancy < (CW+1)'(FIFO_DEPTH);
    imem.imem_req_valid = rst && !branch_taken && room;
    imem.imem_req_addr  = fetch_pc_q;
    req_fire            = imem.imem_req_valid && imem.imem_req_ready;
    instr_valid         = count_q != '0;
    pc                  = instr_valid ? pc_mem_q[rd_ptr_q] : '0;
    instr_out           = instr_valid ? data_mem_q[rd_ptr_q] : NOP_INSTR;
    pop                 = instr_valid && !stall && !branch_taken;
    push                = imem.imem_rsp_valid && !branch_taken && (discard_q == '0);
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    count_d    = count_q;
    inflight_d = inflight_q;
    discard_d  = discard_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    tag_rd_d   = tag_rd_q;
    tag_wr_d   = tag_wr_q;
    if (branch_taken) begin
      fetch_pc_d = branch_target & ~32'h3;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      tag_rd_d   = '0;
      tag_wr_d   = '0;
      inflight_d = inflight_q - CW'(imem.imem_rsp_valid);
      // inflight already counts responses doomed by an earlier redirect, so every
      // response still outstanding after this cycle is wrong-path.
      discard_d  = inflight_d;
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        tag_wr_d   = tag_wr_q + PW'(1);
      end
      inflight_d = inflight_q + CW'(req_fire) - CW'(imem.imem_rsp_valid);
      if (imem.imem_rsp_valid && (discard_q != '0)) discard_d = discard_q - CW'(1);
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
        tag_rd_d = tag_rd_q + PW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      count_q    <= '0;
      inflight_q <= '0;
      discard_q  <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      tag_rd_q   <= '0;
      tag_wr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      tag_rd_q   <= tag_rd_d;
      tag_wr_q   <= tag_wr_d;
    end
  end

  // Issued-address tags pair each live response with its PC.
  always_ff @(posedge clk) begin
    if (req_fire) tag_mem_q[tag_wr_q] <= fetch_pc_q;
    if (push) begin
      pc_mem_q[wr_ptr_q]   <= tag_mem_q[tag_rd_q];
      data_mem_q[wr_ptr_q] <= imem.imem_rsp_data;
    end
  end

  push_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    push |-> (count_q < CW'(FIFO_DEPTH)));
endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: expected request addresses and output
// PCs are queued by the stimulus and checked by a negedge monitor.
module tb_if_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic [31:0] pc, instr_out;
  logic        instr_valid;

  if_fetch_unit_if imem ();

  if_fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .FIFO_DEPTH(2),
    .NOP_INSTR (NOP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .imem         (imem),
    .pc           (pc),
    .instr_out    (instr_out),
    .instr_valid  (instr_valid)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int          n_out = 0;
  int          cyc = 0;
  int          lat = 1;
  logic [31:0] exp_addr[$];
  logic [31:0] exp_pc[$];
  pend_t       pend[$];

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic new_path(input logic [31:0] base, input int n);
    exp_addr.delete();
    exp_pc.delete();
    for (int i = 0; i < n; i++) begin
      exp_addr.push_back(base + 32'(4 * i));
      exp_pc.push_back(base + 32'(4 * i));
    end
  endtask

  // Memory model: fixed latency, in order, cleared by the shared reset.
  initial begin
    imem.imem_rsp_valid = 1'b0;
    imem.imem_rsp_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (!rst) begin
        pend.delete();
        imem.imem_rsp_valid = 1'b0;
      end else if (pend.size() != 0 && pend[0].due <= cyc) begin
        imem.imem_rsp_valid = 1'b1;
        imem.imem_rsp_data  = mdata(pend[0].addr);
        void'(pend.pop_front());
      end else begin
        imem.imem_rsp_valid = 1'b0;
      end
    end
  end

  // Monitor: request handshakes and consumed outputs against the queues.
  initial begin
    pend_t       p;
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (rst && imem.imem_req_valid && imem.imem_req_ready) begin
        if (exp_addr.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL req_unexpected: got addr %h expected no request", imem.imem_req_addr);
        end else begin
          chk("req_addr", imem.imem_req_addr, exp_addr.pop_front());
        end
        p.addr = imem.imem_req_addr;
        p.due  = cyc + lat;
        pend.push_back(p);
      end
      if (rst && instr_valid && !stall && !branch_taken) begin
        n_out++;
        if (exp_pc.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL out_unexpected: got pc %h expected no output", pc);
        end else begin
          e = exp_pc.pop_front();
          chk("out_pc", pc, e);
          chk("out_instr", instr_out, mdata(e));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int base;
    imem.imem_req_ready = 1'b1;

    // Reset values
    tick();
    tick();
    @(negedge clk);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_pc", pc, 32'd0);
    chk("rst_instr", instr_out, NOP);
    chk("rst_req_valid", 32'(imem.imem_req_valid), 32'd0);
    chk("rst_req_addr", imem.imem_req_addr, 32'd0);

    // Release and first-fetch latency with 1-cycle memory
    tick();
    new_path(32'h0, 32);
    rst = 1'b1;
    @(negedge clk);
    chk("p1_req0_valid", 32'(imem.imem_req_valid), 32'd1);
    chk("p1_req0_addr", imem.imem_req_addr, 32'h0);
    tick();
    @(negedge clk);
    chk("p1_k1_valid", 32'(instr_valid), 32'd0);
    chk("p1_k1_addr", imem.imem_req_addr, 32'h4);
    tick();
    @(negedge clk);
    chk("p1_k2_valid", 32'(instr_valid), 32'd1);
    chk("p1_k2_pc", pc, 32'h0);
    repeat (8) tick();

    // Stall: head frozen, requests stop once buffer + inflight is full
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      @(negedge clk);
      if (i >= 2) begin
        chk("p2_stall_valid", 32'(instr_valid), 32'd1);
        chk("p2_stall_pc", pc, exp_pc[0]);
        chk("p2_stall_instr", instr_out, mdata(exp_pc[0]));
      end
      if (i == 4) chk("p2_stall_req_valid", 32'(imem.imem_req_valid), 32'd0);
    end
    tick();
    stall = 1'b0;
    base = n_out;
    repeat (10) tick();
    chk("p2_resume", 32'(n_out - base >= 4), 32'd1);

    // Branch while stalled with a full buffer; then 3-cycle memory
    stall = 1'b1;
    lat = 3;
    repeat (6) tick();
    @(negedge clk);
    chk("p4_full_valid", 32'(instr_valid), 32'd1);
    tick();
    branch_taken  = 1'b1;
    branch_target = 32'h0000_0083;
    new_path(32'h80, 32);
    @(negedge clk);
    chk("p4_br_req_valid", 32'(imem.imem_req_valid), 32'd0);
    tick();
    branch_taken = 1'b0;
    @(negedge clk);
    chk("p4_flush_valid", 32'(instr_valid), 32'd0);
    chk("p4_flush_pc", pc, 32'd0);
    chk("p4_flush_instr", instr_out, NOP);
    chk("p4_new_req_valid", 32'(imem.imem_req_valid), 32'd1);
    chk("p4_new_req_addr", imem.imem_req_addr, 32'h80);
    tick();
    @(negedge clk);
    chk("p3_second_req_addr", imem.imem_req_addr, 32'h84);

    // Redirect with two requests in flight: both stale words dropped
    tick();
    branch_taken  = 1'b1;
    branch_target = 32'h0000_0100;
    stall = 1'b0;
    new_path(32'h100, 32);
    @(negedge clk);
    chk("p3_br_req_valid", 32'(imem.imem_req_valid), 32'd0);
    tick();
    branch_taken = 1'b0;
    @(negedge clk);
    chk("p3_b1_valid", 32'(instr_valid), 32'd0);
    chk("p3_b1_req_valid", 32'(imem.imem_req_valid), 32'd0);
    tick();
    @(negedge clk);
    chk("p3_b2_req_valid", 32'(imem.imem_req_valid), 32'd1);
    chk("p3_b2_req_addr", imem.imem_req_addr, 32'h100);
    for (int i = 0; i < 20; i++) begin
      tick();
      @(negedge clk);
      if (instr_valid) break;
    end
    chk("p3_first_valid", 32'(instr_valid), 32'd1);
    chk("p3_first_pc", pc, 32'h100);

    // Memory not ready: request held, fetch PC static
    repeat (6) tick();
    imem.imem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      @(negedge clk);
      chk("p5_hold_addr", imem.imem_req_addr, exp_addr[0]);
      if (i == 3) chk("p5_hold_valid", 32'(imem.imem_req_valid), 32'd1);
    end

    // Reset mid-stream with a response pending, then PC wrap
    tick();
    imem.imem_req_ready = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("p6_rst_valid", 32'(instr_valid), 32'd0);
    chk("p6_rst_pc", pc, 32'd0);
    chk("p6_rst_instr", instr_out, NOP);
    chk("p6_rst_req_valid", 32'(imem.imem_req_valid), 32'd0);
    chk("p6_rst_req_addr", imem.imem_req_addr, 32'd0);
    tick();
    tick();
    new_path(32'h0, 32);
    rst = 1'b1;
    @(negedge clk);
    chk("p6_first_req_valid", 32'(imem.imem_req_valid), 32'd1);
    chk("p6_first_req_addr", imem.imem_req_addr, 32'h0);
    repeat (3) tick();
    tick();
    branch_taken  = 1'b1;
    branch_target = 32'hFFFF_FFF8;
    new_path(32'hFFFF_FFF8, 16);
    tick();
    branch_taken = 1'b0;
    base = n_out;
    for (int i = 0; i < 60; i++) begin
      if (n_out - base >= 4) break;
      tick();
    end
    chk("p6_wrap_progress", 32'(n_out - base >= 4), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
